// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction prefetch buffer: word sizes, NOP
// encoding, default reset PC and the queue entry layout.
package fetch_queue_pkg;

  localparam int                    WORD_WIDTH       = 32;
  localparam logic [WORD_WIDTH-1:0] ZERO_WORD        = '0;
  localparam logic [WORD_WIDTH-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [WORD_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int                    DROP_W           = 8;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] pc;
    logic [WORD_WIDTH-1:0] instr;
  } fq_entry_t;

  function automatic logic [WORD_WIDTH-1:0] next_pc(input logic [WORD_WIDTH-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order queue of {pc, instr} entries with synchronous flush; the head is
// read straight from the storage array, so it is a registered value.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  fq_entry_t push_data,
  input  logic      pop,
  input  logic      clear,
  output logic [AW:0] count,
  output logic      empty,
  output logic      full,
  output fq_entry_t head
);

  fq_entry_t        r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop;

  assign w_pop = pop && (r_count != '0);
  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign head  = r_mem[r_rd_ptr];

  // Storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push && !clear) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch buffer: sequential fetch over a req/gnt/rvalid port,
// in-order buffering toward decode, and redirect with stale-response dropping.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                    DEPTH    = 4,
  parameter logic [WORD_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect,
  input  logic [WORD_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [WORD_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [WORD_WIDTH-1:0] imem_rdata,
  input  logic                  stallD,
  output logic                  instr_valid,
  output logic [WORD_WIDTH-1:0] instrF,
  output logic [WORD_WIDTH-1:0] pcF
);

  localparam int AW = $clog2(DEPTH);

  logic [WORD_WIDTH-1:0] r_fetch_pc;
  logic [WORD_WIDTH-1:0] r_rsp_pc;
  logic [AW:0]           r_outstanding;
  logic [DROP_W-1:0]     r_drop_cnt;

  logic [AW:0]   w_count;
  logic          w_empty;
  logic          w_full;
  fq_entry_t     w_head;
  fq_entry_t     w_push_data;
  logic [AW+1:0] w_inflight;
  logic          w_grant;
  logic          w_drop;
  logic          w_keep;
  logic          w_push;
  logic          w_pop;

  // r_outstanding counts only fetches whose responses will be kept; stale
  // ones move into r_drop_cnt on redirect and no longer consume credit.
  assign w_inflight = {1'b0, w_count} + {1'b0, r_outstanding};
  assign imem_req   = rst && !redirect && (w_inflight < (AW+2)'(DEPTH));
  assign imem_addr  = r_fetch_pc;
  assign w_grant    = imem_req && imem_gnt;
  assign w_drop     = imem_rvalid && (r_drop_cnt != '0);
  assign w_keep     = imem_rvalid && !w_drop;
  assign w_push     = w_keep && !redirect;
  assign w_pop      = !w_empty && !stallD && !redirect;

  assign w_push_data = '{pc: r_rsp_pc, instr: imem_rdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .clear     (redirect),
    .count     (w_count),
    .empty     (w_empty),
    .full      (w_full),
    .head      (w_head)
  );

  assign instr_valid = !w_empty;
  assign instrF      = w_empty ? NOP_INSTR : w_head.instr;
  assign pcF         = w_empty ? ZERO_WORD : w_head.pc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else if (redirect) begin
      r_fetch_pc    <= redirect_pc;
      r_rsp_pc      <= redirect_pc;
      r_outstanding <= '0;
      r_drop_cnt    <= r_drop_cnt + DROP_W'(r_outstanding) - DROP_W'(imem_rvalid);
    end else begin
      if (w_grant) r_fetch_pc <= next_pc(r_fetch_pc);
      if (w_push)  r_rsp_pc   <= next_pc(r_rsp_pc);
      if (w_drop)  r_drop_cnt <= r_drop_cnt - 1'b1;
      case ({w_grant, w_keep})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_push) assert (!w_full);
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: an in-order memory with variable latency
// and an epoch-tagged reference model of the instruction stream seen by decode.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stallD;
  logic        instr_valid;
  logic [31:0] instrF;
  logic [31:0] pcF;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stallD      (stallD),
    .instr_valid (instr_valid),
    .instrF      (instrF),
    .pcF         (pcF)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          ready;
    int          epoch;
  } pend_t;

  pend_t       mem_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] m_fetch_pc;
  int          epoch;
  int          cyc;
  int          lat_min;
  int          lat_max;
  int          pops;
  bit          chk_on;
  int          n_checks;
  int          n_fail;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic cycle(input logic rstv, input logic redir, input logic [31:0] rpc,
                       input logic stl, input logic gn);
    logic  exp_valid;
    logic  exp_req;
    logic  keep;
    int    kept;
    pend_t e;
    @(posedge clk);
    #1;
    rst         = rstv;
    redirect    = redir;
    redirect_pc = rpc;
    stallD      = stl;
    imem_gnt    = gn;
    if (rstv && mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #3;
    kept = 0;
    foreach (mem_q[i]) if (mem_q[i].epoch == epoch) kept++;
    exp_valid = (exp_q.size() != 0);
    exp_req   = rstv && !redir && ((exp_q.size() + kept) < DEPTH);
    if (chk_on) begin
      check_eq("instr_valid", {31'b0, instr_valid}, {31'b0, exp_valid});
      if (exp_valid) begin
        check_eq("pcF", pcF, exp_q[0][63:32]);
        check_eq("instrF", instrF, exp_q[0][31:0]);
      end else begin
        check_eq("pcF_empty", pcF, 32'h0);
        check_eq("instrF_nop", instrF, 32'h0);
      end
      check_eq("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      if (exp_req && imem_req) check_eq("imem_addr", imem_addr, m_fetch_pc);
    end
    if (!rstv) begin
      exp_q.delete();
      mem_q.delete();
      epoch++;
      m_fetch_pc = RESET_PC;
    end else begin
      keep = 1'b0;
      if (imem_rvalid) begin
        e    = mem_q.pop_front();
        keep = !redir && (e.epoch == epoch);
      end
      if (redir) begin
        exp_q.delete();
        epoch++;
        m_fetch_pc = rpc;
      end else begin
        if (exp_valid && !stl) begin
          void'(exp_q.pop_front());
          pops++;
        end
        if (keep) exp_q.push_back({e.addr, mem_word(e.addr)});
      end
      if (imem_req && imem_gnt) begin
        mem_q.push_back('{addr: imem_addr,
                          ready: cyc + int'($urandom_range(lat_max, lat_min)),
                          epoch: epoch});
        m_fetch_pc += 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n, input logic stl);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 32'h0, stl, 1'b1);
  endtask

  initial begin
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; stallD = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    m_fetch_pc = RESET_PC; epoch = 0; cyc = 0; pops = 0;
    lat_min = 1; lat_max = 1; chk_on = 1'b0; n_checks = 0; n_fail = 0;

    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_on = 1'b1;
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    run(20, 1'b0);
    run(10, 1'b1);
    run(10, 1'b0);

    lat_min = 3; lat_max = 3;
    run(6, 1'b0);
    cycle(1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b1);
    run(15, 1'b0);

    lat_min = 1; lat_max = 1;
    run(5, 1'b0);
    cycle(1'b1, 1'b1, 32'h0000_0180, 1'b0, 1'b1);
    run(8, 1'b0);

    lat_min = 2; lat_max = 2;
    run(5, 1'b0);
    cycle(1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 32'h0000_0300, 1'b0, 1'b1);
    run(15, 1'b0);

    cycle(1'b1, 1'b1, 32'hFFFF_FFF0, 1'b0, 1'b1);
    run(12, 1'b0);

    lat_min = 1; lat_max = 1;
    run(8, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    run(15, 1'b0);

    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      logic        r_rst;
      logic        r_red;
      logic [31:0] r_pc;
      r_rst = ($urandom_range(999, 0) >= 3);
      r_red = ($urandom_range(99, 0) < 5);
      r_pc  = ($urandom_range(9, 0) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      cycle(r_rst, r_red, r_pc, ($urandom_range(99, 0) < 30), ($urandom_range(99, 0) < 70));
    end

    check_eq("pops_min", {31'b0, (pops >= 500)}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
